count_monitor: RTL

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/count_monitor.sv
// count_monitor: checks that a sampled 6-bit up-counter advances by exactly one per valid sample.
// Latency: one cycle; every output is a flop reflecting the sample accepted at the previous edge.
// Backpressure: none; every IN_VALID sample is consumed, CLR wins and discards a same-cycle sample.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-low reset
//   IN_VALID   IN_DATA holds a counter sample this cycle
//   IN_DATA    6-bit counter sample
//   CLR        synchronous clear of status and statistics (back to hunting)
//   LOCKED     stream is being tracked with correct increments
//   ERR        sticky sequence error seen while locked
//   WRAP_PULSE one-cycle pulse per legal 63->0 wrap
//   WRAP_CNT   saturating count of legal wraps
//   ERR_CNT    saturating count of sequence errors
//   EXP        next expected sample value
module count_monitor #(
  parameter int unsigned LOCK_N = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  input  logic [5:0] IN_DATA,
  input  logic       CLR,
  output logic       LOCKED,
  output logic       ERR,
  output logic       WRAP_PULSE,
  output logic [7:0] WRAP_CNT,
  output logic [7:0] ERR_CNT,
  output logic [5:0] EXP
);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N_W = 4'(LOCK_N);

  state_t     state_q, state_nxt;
  logic [3:0] match_q, match_nxt;
  logic [5:0] exp_q, exp_nxt;
  logic       err_q, err_nxt;
  logic       wrap_pulse_q, wrap_pulse_nxt;
  logic [7:0] wrap_cnt_q, wrap_cnt_nxt;
  logic [7:0] err_cnt_q, err_cnt_nxt;
  logic       locked_q;

  logic hit;
  logic wrap_evt;
  logic lock_miss;

  assign hit       = (IN_DATA == exp_q);
  // A zero sample only counts as a wrap when zero was actually expected; a zero
  // arriving early is an upstream counter reset and falls into the mismatch path.
  assign wrap_evt  = (state_q != ST_HUNT) && hit && (exp_q == 6'd0);
  assign lock_miss = (state_q == ST_LOCK) && !hit;

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_HUNT;
      match_q      <= '0;
      exp_q        <= '0;
      err_q        <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
      err_cnt_q    <= '0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      match_q      <= match_nxt;
      exp_q        <= exp_nxt;
      err_q        <= err_nxt;
      wrap_pulse_q <= wrap_pulse_nxt;
      wrap_cnt_q   <= wrap_cnt_nxt;
      err_cnt_q    <= err_cnt_nxt;
      // LOCKED is its own flop so the output is registered, not decoded from state.
      locked_q     <= (state_nxt == ST_LOCK);
    end
  end

  // Next-state and match counter
  always_comb begin
    state_nxt = state_q;
    match_nxt = match_q;
    if (CLR) begin
      state_nxt = ST_HUNT;
      match_nxt = '0;
    end else if (IN_VALID) begin
      unique case (state_q)
        ST_HUNT: begin
          state_nxt = ST_SYNC;
          match_nxt = '0;
        end
        ST_SYNC: begin
          if (hit) begin
            if (match_q + 4'd1 == LOCK_N_W) begin
              state_nxt = ST_LOCK;
              match_nxt = '0;
            end else begin
              match_nxt = match_q + 4'd1;
            end
          end else begin
            // Re-reference silently: errors only count once we were locked.
            match_nxt = '0;
          end
        end
        ST_LOCK: begin
          if (!hit) begin
            state_nxt = ST_SYNC;
            match_nxt = '0;
          end
        end
        default: begin
          state_nxt = ST_HUNT;
          match_nxt = '0;
        end
      endcase
    end
  end

  // Expected value, flags and statistics
  always_comb begin
    exp_nxt        = exp_q;
    err_nxt        = err_q;
    wrap_pulse_nxt = 1'b0;
    wrap_cnt_nxt   = wrap_cnt_q;
    err_cnt_nxt    = err_cnt_q;
    if (CLR) begin
      exp_nxt      = '0;
      err_nxt      = 1'b0;
      wrap_cnt_nxt = '0;
      err_cnt_nxt  = '0;
    end else if (IN_VALID) begin
      exp_nxt = IN_DATA + 6'd1;  // natural 6-bit wrap, 63+1 = 0
      if (wrap_evt) begin
        wrap_pulse_nxt = 1'b1;
        if (wrap_cnt_q != 8'hFF) wrap_cnt_nxt = wrap_cnt_q + 8'd1;
      end
      if (lock_miss) begin
        err_nxt = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_nxt = err_cnt_q + 8'd1;
      end
    end
  end

  assign LOCKED     = locked_q;
  assign ERR        = err_q;
  assign WRAP_PULSE = wrap_pulse_q;
  assign WRAP_CNT   = wrap_cnt_q;
  assign ERR_CNT    = err_cnt_q;
  assign EXP        = exp_q;

endmodule
